// File: rtl/opcode_fetch.sv
// Byte-serial instruction fetcher: assembles opcode, CB prefix and
// immediates into one decoded bundle handed off with a valid/ready handshake.
module opcode_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  op_byte,
    output logic        op_cb,
    output logic [15:0] op_imm,
    output logic [1:0]  op_len,
    output logic [15:0] op_pc
);

    localparam logic [2:0] FETCH_OP = 3'd0;
    localparam logic [2:0] FETCH_CB = 3'd1;
    localparam logic [2:0] FETCH_LO = 3'd2;
    localparam logic [2:0] FETCH_HI = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;

    logic [2:0]  state;
    logic [15:0] pc;
    logic        hi_pend;
    logic [7:0]  byte_q;
    logic        cb_q;
    logic [15:0] imm_q;
    logic [1:0]  len_q;
    logic [15:0] opc_pc;

    function automatic logic is_imm8(input logic [7:0] b);
        case (b)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hE8, 8'hF0, 8'hF8: is_imm8 = 1'b1;
            default:                    is_imm8 = 1'b0;
        endcase
    endfunction

    function automatic logic is_imm16(input logic [7:0] b);
        case (b)
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA: is_imm16 = 1'b1;
            default:      is_imm16 = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH_OP;
            pc      <= 16'h0000;
            hi_pend <= 1'b0;
            byte_q  <= 8'h00;
            cb_q    <= 1'b0;
            imm_q   <= 16'h0000;
            len_q   <= 2'd0;
            opc_pc  <= 16'h0000;
        end else if (pc_load) begin
            // Redirect wins over any ack or handshake in the same cycle
            state   <= FETCH_OP;
            pc      <= pc_load_val;
            hi_pend <= 1'b0;
            cb_q    <= 1'b0;
            imm_q   <= 16'h0000;
        end else begin
            case (state)
                FETCH_OP: if (mem_ack) begin
                    pc      <= pc + 16'd1;
                    opc_pc  <= pc;
                    byte_q  <= mem_rdata;
                    cb_q    <= 1'b0;
                    imm_q   <= 16'h0000;
                    len_q   <= 2'd1;
                    hi_pend <= is_imm16(mem_rdata);
                    if (mem_rdata == 8'hCB)
                        state <= FETCH_CB;
                    else if (is_imm8(mem_rdata) || is_imm16(mem_rdata))
                        state <= FETCH_LO;
                    else
                        state <= HOLD;
                end
                FETCH_CB: if (mem_ack) begin
                    pc     <= pc + 16'd1;
                    byte_q <= mem_rdata;
                    cb_q   <= 1'b1;
                    len_q  <= 2'd2;
                    state  <= HOLD;
                end
                FETCH_LO: if (mem_ack) begin
                    pc         <= pc + 16'd1;
                    imm_q[7:0] <= mem_rdata;
                    len_q      <= 2'd2;
                    state      <= hi_pend ? FETCH_HI : HOLD;
                end
                FETCH_HI: if (mem_ack) begin
                    pc          <= pc + 16'd1;
                    imm_q[15:8] <= mem_rdata;
                    len_q       <= 2'd3;
                    state       <= HOLD;
                end
                HOLD: if (op_ready) begin
                    state <= FETCH_OP;
                end
                default: state <= FETCH_OP;
            endcase
        end
    end

    // Outputs are forced quiet combinationally so reset holds them from its first cycle
    assign mem_rd   = !rst && (state != HOLD);
    assign mem_addr = rst ? 16'h0000 : pc;
    assign op_valid = !rst && (state == HOLD);
    assign op_byte  = rst ? 8'h00 : byte_q;
    assign op_cb    = !rst && cb_q;
    assign op_imm   = rst ? 16'h0000 : imm_q;
    assign op_len   = rst ? 2'd0 : len_q;
    assign op_pc    = rst ? 16'h0000 : opc_pc;

endmodule

// File: tb/tb_opcode_fetch.sv
// Scoreboard bench for opcode_fetch: a byte memory answers reads with
// one-cycle latency; a monitor checks each presented instruction.
module tb_opcode_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [7:0]  op_byte;
    logic        op_cb;
    logic [15:0] op_imm;
    logic [1:0]  op_len;
    logic [15:0] op_pc;

    typedef struct packed {
        logic [7:0]  b;
        logic        cb;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem [0:65535];
    int         tests = 0;
    int         fails = 0;
    logic       seen = 1'b0;

    opcode_fetch dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc_load(pc_load), .pc_load_val(pc_load_val),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_byte(op_byte), .op_cb(op_cb), .op_imm(op_imm),
        .op_len(op_len), .op_pc(op_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: one-cycle latency, ack pulses alternate with idle cycles
    always @(negedge clk) begin
        if (mem_rd && !mem_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'h00;
        end
    end

    always @(negedge clk) begin
        if (op_valid && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                chk("unexpected_op", {16'h0, op_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("op_byte", {24'h0, op_byte}, {24'h0, e.b});
                chk("op_cb", {31'h0, op_cb}, {31'h0, e.cb});
                chk("op_imm", {16'h0, op_imm}, {16'h0, e.imm});
                chk("op_len", {30'h0, op_len}, {30'h0, e.len});
                chk("op_pc", {16'h0, op_pc}, {16'h0, e.pc});
            end
        end else if (!op_valid) begin
            seen = 1'b0;
        end
    end

    task automatic push(input logic [7:0] b, input logic cb,
                        input logic [15:0] imm, input logic [1:0] len,
                        input logic [15:0] pc);
        exp_t e;
        e.b = b; e.cb = cb; e.imm = imm; e.len = len; e.pc = pc;
        q.push_back(e);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!op_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", {31'h0, op_valid}, 32'h1);
    endtask

    task automatic wait_addr(input logic [15:0] a, input logic need_ack);
        int n = 0;
        while (!(mem_addr == a && (mem_ack || !need_ack)) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("addr_timeout", {16'h0, mem_addr}, {16'h0, a});
    endtask

    task automatic accept();
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] a);
        pc_load     = 1'b1;
        pc_load_val = a;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        {mem[16'h0100], mem[16'h0101], mem[16'h0102]} = 24'hC3_50_01;
        {mem[16'h0103], mem[16'h0104]} = 16'hCB_37;
        mem[16'h0105] = 8'hD3;
        {mem[16'h0106], mem[16'h0107]} = 16'hE0_FF;
        {mem[16'h0108], mem[16'h0109]} = 16'hCB_11;
        {mem[16'h0200], mem[16'h0201], mem[16'h0202]} = 24'hCD_34_12;
        mem[16'h0038] = 8'hC9;
        mem[16'hFFFF] = 8'h3E;
        {mem[16'h0300], mem[16'h0301], mem[16'h0302]} = 24'h01_AA_BB;

        repeat (3) @(negedge clk);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_op_valid", {31'h0, op_valid}, 32'h0);
        chk("rst_fields", {op_byte, op_cb, op_imm, op_len, op_pc},
            {8'h00, 1'b0, 16'h0000, 2'd0, 16'h0000});
        rst = 1'b0;
        #1;
        chk("post_rst_rd", {15'h0, mem_rd, mem_addr}, {15'h0, 1'b1, 16'h0});

        push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0000);
        wait_valid();
        accept();
        chk("next_after_nop", {16'h0, mem_addr}, 32'h0001);
        mem[16'h0000] = 8'h42;

        redirect(16'h0100);
        push(8'hC3, 1'b0, 16'h0150, 2'd3, 16'h0100);
        wait_valid();
        accept();
        chk("next_after_c3", {16'h0, mem_addr}, 32'h0103);

        push(8'h37, 1'b1, 16'h0000, 2'd2, 16'h0103);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {mem_rd, op_valid, op_cb, op_byte, op_len},
                {1'b0, 1'b1, 1'b1, 8'h37, 2'd2});
            @(negedge clk);
        end
        accept();
        chk("bp_release", {mem_rd, op_valid, mem_addr},
            {1'b1, 1'b0, 16'h0105});

        push(8'hD3, 1'b0, 16'h0000, 2'd1, 16'h0105);
        wait_valid();
        accept();
        push(8'hE0, 1'b0, 16'h00FF, 2'd2, 16'h0106);
        wait_valid();
        accept();
        push(8'h11, 1'b1, 16'h0000, 2'd2, 16'h0108);
        wait_valid();
        accept();

        redirect(16'h0200);
        wait_addr(16'h0202, 1'b1);
        pc_load     = 1'b1;
        pc_load_val = 16'h0038;
        @(negedge clk);
        pc_load = 1'b0;
        chk("redir_addr", {op_valid, mem_rd, mem_addr},
            {1'b0, 1'b1, 16'h0038});
        push(8'hC9, 1'b0, 16'h0000, 2'd1, 16'h0038);
        wait_valid();

        op_ready    = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 16'hFFFF;
        @(negedge clk);
        op_ready = 1'b0;
        pc_load  = 1'b0;
        chk("hs_redir", {op_valid, mem_rd, mem_addr},
            {1'b0, 1'b1, 16'hFFFF});

        push(8'h3E, 1'b0, 16'h0042, 2'd2, 16'hFFFF);
        wait_valid();
        accept();
        chk("wrap_next", {16'h0, mem_addr}, 32'h0001);

        redirect(16'h0300);
        wait_addr(16'h0301, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", {mem_rd, op_valid, mem_addr, op_imm, op_len},
            {1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0});
        rst = 1'b0;
        push(8'h42, 1'b0, 16'h0000, 2'd1, 16'h0000);
        wait_valid();
        accept();
        chk("after_rst_next", {16'h0, mem_addr}, 32'h0001);

        chk("queue_drained", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
